// File: rtl/mem_bus_pkg.sv
// Shared constants, state encoding and address decode helpers
// for the RAM / memory-mapped I/O bus controller.
package mem_bus_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int RAM_AW = 8;
    localparam int SW_W   = 10;

    localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
    localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;

    // Top address bit clear selects the 256-word RAM.
    localparam logic RAM_SPACE = 1'b0;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LD  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    function automatic logic is_ram(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1] == RAM_SPACE;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Requester ports, RAM port and I/O pins of the bus controller.
// slave = controller side, master = requesters/RAM/board side.
interface mem_bus_ctrl_if;
    import mem_bus_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;
    logic [DATA_W-1:0] ld_rdata;

    logic [RAM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic [SW_W-1:0]   sw;
    logic [SW_W-1:0]   led;
    logic              bus_err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_ack, ld_rdata,
        output mem_addr, mem_we, mem_din,
        input  mem_dout,
        input  sw,
        output led, bus_err
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_ack, ld_rdata,
        input  mem_addr, mem_we, mem_din,
        output mem_dout,
        output sw,
        input  led, bus_err
    );

endinterface

// File: rtl/mem_bus_arb.sv
// Two-way round-robin arbiter between CPU and loader.
// A lone requester always wins; on a tie the port not granted last wins.
module mem_bus_arb
    import mem_bus_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic ld_req,
    input  logic take,
    output logic grant
);

    logic last_grant;

    // Pick the winner for the current request pattern.
    always_comb begin
        grant = ~last_grant;
        unique case (1'b1)
            cpu_req && !ld_req: grant = PORT_CPU;
            ld_req && !cpu_req: grant = PORT_LD;
            default:            grant = ~last_grant;
        endcase
    end

    // Remember who was granted so the next tie flips.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= PORT_LD;
        end else if (take) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Shares one synchronous RAM between CPU and loader, decodes
// LED/switch I/O and returns a one-cycle ack per transaction.
module mem_bus_ctrl
    import mem_bus_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mem_bus_ctrl_if.slave bus
);

    state_t            state;
    logic              port;
    logic              t_we;
    logic [ADDR_W-1:0] t_addr;

    logic              cpu_ack;
    logic              ld_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] ld_rdata;
    logic [RAM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [SW_W-1:0]   led;
    logic              bus_err;

    logic              any_req;
    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] sw_word;

    assign any_req   = bus.cpu_req | bus.ld_req;
    assign sel_we    = (grant == PORT_CPU) ? bus.cpu_we    : bus.ld_we;
    assign sel_addr  = (grant == PORT_CPU) ? bus.cpu_addr  : bus.ld_addr;
    assign sel_wdata = (grant == PORT_CPU) ? bus.cpu_wdata : bus.ld_wdata;
    assign sw_word   = {{(DATA_W-SW_W){1'b0}}, bus.sw};

    mem_bus_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (bus.cpu_req),
        .ld_req  (bus.ld_req),
        .take    (state == IDLE && any_req),
        .grant   (grant)
    );

    // Transaction sequencer with registered acks, rdata and RAM controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            port      <= PORT_CPU;
            t_we      <= 1'b0;
            t_addr    <= '0;
            cpu_ack   <= 1'b0;
            ld_ack    <= 1'b0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_din   <= '0;
            led       <= '0;
            bus_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        port     <= grant;
                        t_we     <= sel_we;
                        t_addr   <= sel_addr;
                        mem_addr <= sel_addr[RAM_AW-1:0];
                        mem_din  <= sel_wdata;
                        mem_we   <= sel_we & is_ram(sel_addr);
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_we <= 1'b0;
                    if (is_ram(t_addr) && !t_we) begin
                        state <= WAIT;
                    end else begin
                        state   <= ACK;
                        cpu_ack <= (port == PORT_CPU);
                        ld_ack  <= (port == PORT_LD);
                        if (!is_ram(t_addr)) begin
                            if (t_we && t_addr == LED_ADDR) begin
                                led <= mem_din[SW_W-1:0];
                            end else if (!t_we && t_addr == SW_ADDR) begin
                                if (port == PORT_CPU) cpu_rdata <= sw_word;
                                else                  ld_rdata  <= sw_word;
                            end else begin
                                bus_err <= 1'b1;
                                if (!t_we) begin
                                    if (port == PORT_CPU) cpu_rdata <= '0;
                                    else                  ld_rdata  <= '0;
                                end
                            end
                        end
                    end
                end
                WAIT: begin
                    if (port == PORT_CPU) cpu_rdata <= bus.mem_dout;
                    else                  ld_rdata  <= bus.mem_dout;
                    cpu_ack <= (port == PORT_CPU);
                    ld_ack  <= (port == PORT_LD);
                    state   <= ACK;
                end
                ACK: begin
                    cpu_ack <= 1'b0;
                    ld_ack  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ack   = cpu_ack;
    assign bus.ld_ack    = ld_ack;
    assign bus.cpu_rdata = cpu_rdata;
    assign bus.ld_rdata  = ld_rdata;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_din   = mem_din;
    assign bus.led       = led;
    assign bus.bus_err   = bus_err;

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Memory/I-O bus controller that shares the single synchronous RAM between two requesters: the CPU data port and a program-loader port. It decodes a 9-bit word address into RAM space and memory-mapped I/O (slide switches in, red LEDs out), sequences the RAM's 1-cycle read latency, and returns a one-cycle ack per transaction. It sits between p5_cpu, the loader logic and RAM in the top level, replacing the hard-wired RAM hookup.

Parameters:
ADDR_W, 9, requester word-address width
DATA_W, 16, data width
RAM_AW, 8, RAM address width (256 words at 0x000-0x0FF)
LED_ADDR, 9'h100, write-only LED register address
SW_ADDR, 9'h140, read-only switch address

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU transaction request
cpu_we  in  1  CPU 1=write, 0=read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DATA_W  CPU read data
ld_req, ld_we, ld_addr, ld_wdata  in  1/1/ADDR_W/DATA_W  loader port, same meaning
ld_ack  out  1  loader completion pulse
ld_rdata  out  DATA_W  loader read data
mem_addr  out  RAM_AW  RAM address
mem_we  out  1  RAM write enable
mem_din  out  DATA_W  RAM write data
mem_dout  in  DATA_W  RAM read data, valid 1 cycle after address sampled
sw  in  10  slide switches
led  out  10  LED register
bus_err  out  1  sticky unmapped-access flag

Behaviour:
- Reset (async, reset=0): state IDLE; all acks 0; cpu_rdata, ld_rdata, led, mem_addr, mem_din = 0; mem_we 0; bus_err 0; last_grant = loader. Any in-flight transaction is dropped with no ack; RAM write suppressed.
- FSM states IDLE, ISSUE, WAIT, ACK.
- IDLE: if any req high, pick grantee, latch its we/addr/wdata into the transaction register, go ISSUE. Else stay.
- Arbitration: single requester wins. Both high: grant the port not in last_grant (round-robin); update last_grant on each grant.
- ISSUE: drive mem_addr = addr[RAM_AW-1:0], mem_din = wdata; mem_we = 1 only for a RAM-space write (addr[8]=0), exactly one cycle. RAM read -> WAIT. All other cases -> ACK.
  - LED write: led <= wdata[9:0] at end of ISSUE.
  - Switch read: rdata capture = {6'b0, sw} at end of ISSUE.
  - Unmapped (addr[8]=1, not LED_ADDR/SW_ADDR; includes read of LED_ADDR or write of SW_ADDR): write ignored, read data 0, bus_err <= 1.
- WAIT: capture mem_dout into grantee's rdata register, go ACK.
- ACK: grantee's ack = 1 for exactly this cycle (registered); other ack 0; next state IDLE.
- Latency req-seen-in-IDLE to ack: RAM read 4 cycles (IDLE, ISSUE, WAIT, ACK); all others 3.
- Requester protocol: hold req/we/addr/wdata stable until ack; drop req the cycle after ack. req still high in the IDLE following ACK is a new transaction. Inputs ignored outside IDLE.
- rdata of each port holds its value until that port's next completed read; the non-granted port's rdata never changes.
- bus_err clears only on reset.
- mem_addr/mem_din hold last values outside ISSUE; mem_we 0 outside ISSUE.

Decomposition:
- Shared package/header mem_bus_pkg: state encodings, LED_ADDR, SW_ADDR, RAM-space decode constant, port-ID constants (PORT_CPU, PORT_LD).
- One sub-module natural: mem_bus_arb (2-way round-robin grant + last_grant register). Decode and FSM stay in mem_bus_ctrl.

Test Plan:
- Reset: assert reset=0 mid-ISSUE of a RAM write to 0x010 -> no ack, RAM word 0x010 unchanged, all outputs 0, bus_err 0.
- CPU write 0xABCD to 0x005, then read 0x005 -> cpu_ack 3 cycles after write request, then cpu_rdata=0xABCD with cpu_ack 4 cycles after read request; ld_ack stays 0.
- Both ports request in same cycle, repeated 4 times (CPU reads 0x001, loader writes 0x002) -> grants alternate CPU, loader, CPU, loader; exactly one ack per transaction, never both in one cycle.
- CPU write 0xFFFF to 0x100 -> led=10'h3FF after ack; subsequent read of 0x100 -> rdata 0, bus_err 1.
- sw=10'h2A5, loader reads 0x140 -> ld_rdata=16'h02A5, ld_ack 3 cycles after request, cpu_rdata unchanged.
- Write 0x1234 to 0x1FF -> ack returned, no mem_we pulse, bus_err=1 and stays 1 until reset.
